bnn_image_packer: RTL
=====================

// Module: bnn_image_packer
// PURPOSE
// - Producer side of the bnn_fcc image input stream.
// - Accepts pixels one per handshake and packs them, lowest pixel in lowest bits, into INPUT_BUS_WIDTH AXI-stream beats.
// - Asserts tlast on the final beat of each image and sets keep for a partial final beat.
// - Sits between a pixel source (camera/DMA/testbench model) and the bnn_fcc data_in_* port.
// PARAMETERS
// - INPUT_DATA_WIDTH  8    bits per pixel; multiple of 8.
// - INPUT_BUS_WIDTH   64   output beat width; multiple of INPUT_DATA_WIDTH.
// - IMAGE_PIXELS      784  pixels per image (TOPOLOGY[0]); >= 1.
// - localparam ELEMENTS = INPUT_BUS_WIDTH/INPUT_DATA_WIDTH; BYTES_PER_PIXEL = INPUT_DATA_WIDTH/8.
// PORTS
// - clk             in   1                    clock; the only clock.
// - rst             in   1                    reset; asynchronous, active-high.
// - pixel_valid     in   1                    pixel offered.
// - pixel_ready     out  1                    pixel accepted when valid&&ready.
// - pixel_data      in   INPUT_DATA_WIDTH     pixel value.
// - data_out_valid  out  1                    beat valid (to bnn_fcc data_in_valid).
// - data_out_ready  in   1                    consumer ready.
// - data_out_data   out  INPUT_BUS_WIDTH      packed pixels; slot i at [i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH].
// - data_out_keep   out  INPUT_BUS_WIDTH/8    byte enables.
// - data_out_last   out  1                    final beat of image.
// - image_done      out  1                    one-cycle pulse when the last beat of an image is accepted downstream.
// BEHAVIOUR
// - Reset (async assert): data_out_valid=0, data_out_data=0, data_out_keep=0, data_out_last=0, image_done=0.
//   Slot counter=0, pixel counter=0, pack buffer cleared. Partial beat/image discarded.
//   pixel_ready=0 while rst is high; after release, pixel_ready follows the rule below.
// - State:
//   - slot counter 0..ELEMENTS-1.
//   - pixel counter 0..IMAGE_PIXELS-1.
//   - pack buffer holding ELEMENTS-1 slots.
//   - output register (data/keep/last/valid).
// - Completing pixel: accepted pixel with slot==ELEMENTS-1 or pixel counter==IMAGE_PIXELS-1.
// - pixel_ready = !data_out_valid || data_out_ready || !completing(current counters).
//   - Non-completing pixels are never stalled.
// - Accept of a non-completing pixel:
//   - written into buffer slot.
//   - slot counter +1, pixel counter +1.
// - Accept of a completing pixel, same cycle:
//   - buffer slots 0..slot-1 plus the incoming pixel are loaded into the output register.
//   - slots above the incoming pixel are 0.
//   - keep = ones for bytes [0 .. (slot+1)*BYTES_PER_PIXEL-1], zeros above.
//   - last = (pixel counter==IMAGE_PIXELS-1).
//   - data_out_valid <= 1.
//   - slot counter -> 0. Pixel counter -> +1, or wraps to 0 on the last pixel.
//   - buffer cleared.
// - Latency: beat is visible one cycle after its completing pixel is accepted. Continuous input -> one beat every ELEMENTS cycles, zero bubbles.
// - Output handshake:
//   - data/keep/last are held stable while valid && !ready.
//   - valid clears on transfer unless a new beat loads the same cycle (load has priority; back-to-back beats allowed).
// - Simultaneous output transfer and completing pixel: allowed; new beat replaces old with valid staying 1.
// - image_done: registered, =1 the cycle after a transfer with data_out_last=1; else 0.
// - Next image starts at slot 0 of a fresh beat; pixels never straddle images.
// - No internal overflow possible; unused data bits are always 0.
// - Elaboration checks: $fatal if the width/divisibility rules in PARAMETERS are violated.
// STRUCTURE
// - Shared package bnn_stream_pkg:
//   - function elements(bus_w, data_w).
//   - function keep_mask(num_slots, bytes_per_pixel, keep_w).
//   - typedef of the output beat struct {data, keep, last}.
// - Single flat module; no sub-module needed (output register is inline, not a separate skid buffer).
// TESTING
// - Default params, 784 pixels continuous, data_out_ready=1 -> 98 beats, keep=8'hFF every beat, last only on beat 97, a beat every 8 cycles, pixel_ready never 0, image_done one pulse.
// - Pixels 8'h00..8'h07 -> first beat data_out_data=64'h0706050403020100.
// - IMAGE_PIXELS=20 -> 3 beats; third beat keep=8'h0F, data[63:32]=0, last=1. Next image's pixel 0 lands in byte 0 of a new beat.
// - data_out_ready=0 after first beat -> pixel_ready drops only when the 8th pixel of beat 2 is presented. Beat 1 is held stable. Releasing ready -> beat 2 follows next cycle, no loss or duplication.
// - rst pulsed asynchronously after 13 pixels -> outputs 0 immediately. The following image starts at byte 0 and its last beat is correct.
// - Random pixel_valid/data_out_ready over 3 images with a scoreboard -> exact pixel order, keep/last per beat, stability under backpressure.

Source files
------------

// File: rtl/bnn_stream_pkg.sv
// Shared helpers for the bnn_fcc image input stream.
//   elements()  - pixels carried per output beat
//   keep_mask() - byte-enable mask for a beat holding num_slots pixels
//   MAX_KEEP_W  - widest keep vector keep_mask() can describe
package bnn_stream_pkg;

    localparam int unsigned MAX_KEEP_W = 128;

    function automatic int unsigned elements(input int unsigned bus_w,
                                             input int unsigned data_w);
        return bus_w / data_w;
    endfunction

    // Low num_slots*bytes_per_pixel bits set, everything at or above keep_w clear.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned num_slots,
                                                        input int unsigned bytes_per_pixel,
                                                        input int unsigned keep_w);
        logic [MAX_KEEP_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = (i < keep_w) && (i < num_slots * bytes_per_pixel);
        end
        return mask;
    endfunction

endpackage

// File: rtl/bnn_image_packer.sv
// Packs a pixel stream into INPUT_BUS_WIDTH AXI-stream beats for bnn_fcc.
// Lowest pixel goes in the lowest bits; tlast marks the final beat of each
// image, and keep trims a partial final beat. Images never share a beat.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   pixel_valid/ready/data         pixel input handshake
//   data_out_valid/ready           beat output handshake
//   data_out_data/keep/last        beat payload
//   image_done                     pulse the cycle after the last beat transfers
module bnn_image_packer
    import bnn_stream_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned INPUT_BUS_WIDTH  = 64,
    parameter int unsigned IMAGE_PIXELS     = 784
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pixel_valid,
    output logic                         pixel_ready,
    input  logic [INPUT_DATA_WIDTH-1:0]  pixel_data,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic [INPUT_BUS_WIDTH-1:0]   data_out_data,
    output logic [INPUT_BUS_WIDTH/8-1:0] data_out_keep,
    output logic                         data_out_last,
    output logic                         image_done
);

    localparam int unsigned ELEMENTS        = elements(INPUT_BUS_WIDTH, INPUT_DATA_WIDTH);
    localparam int unsigned BYTES_PER_PIXEL = INPUT_DATA_WIDTH / 8;
    localparam int unsigned KEEP_W          = INPUT_BUS_WIDTH / 8;
    localparam int unsigned SLOT_W          = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    localparam int unsigned PIX_W           = (IMAGE_PIXELS > 1) ? $clog2(IMAGE_PIXELS) : 1;

    if (INPUT_DATA_WIDTH == 0 || (INPUT_DATA_WIDTH % 8) != 0 ||
        INPUT_BUS_WIDTH < INPUT_DATA_WIDTH ||
        (INPUT_BUS_WIDTH % INPUT_DATA_WIDTH) != 0 ||
        KEEP_W > MAX_KEEP_W || IMAGE_PIXELS < 1) begin : g_param_check
        $fatal(1, "bnn_image_packer: illegal width/pixel parameters");
    end

    typedef struct packed {
        logic [INPUT_BUS_WIDTH-1:0] data;
        logic [KEEP_W-1:0]          keep;
        logic                       last;
    } beat_t;

    logic [SLOT_W-1:0]          slot_q, slot_d;
    logic [PIX_W-1:0]           pix_q, pix_d;
    // Full bus width so the completing pixel can simply be OR-ed in; the top
    // slot is never written and stays zero.
    logic [INPUT_BUS_WIDTH-1:0] buf_q, buf_d;
    beat_t                      beat_q, beat_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;

    logic                       last_pixel;
    logic                       completing;
    logic                       accept;
    logic                       transfer;
    logic [31:0]                shamt;

    always_comb begin
        last_pixel  = (pix_q == PIX_W'(IMAGE_PIXELS - 1));
        completing  = (slot_q == SLOT_W'(ELEMENTS - 1)) || last_pixel;
        // Only a completing pixel needs the output register, so it alone can stall.
        pixel_ready = !rst && (!valid_q || data_out_ready || !completing);
        accept      = pixel_valid && pixel_ready;
        transfer    = valid_q && data_out_ready;
        shamt       = 32'(slot_q) * INPUT_DATA_WIDTH;

        slot_d  = slot_q;
        pix_d   = pix_q;
        buf_d   = buf_q;
        beat_d  = beat_q;
        valid_d = valid_q && !data_out_ready;
        done_d  = transfer && beat_q.last;

        if (accept) begin
            if (completing) begin
                beat_d.data = buf_q | (INPUT_BUS_WIDTH'(pixel_data) << shamt);
                beat_d.keep = KEEP_W'(keep_mask(32'(slot_q) + 32'd1, BYTES_PER_PIXEL, KEEP_W));
                beat_d.last = last_pixel;
                valid_d     = 1'b1;
                slot_d      = '0;
                pix_d       = last_pixel ? '0 : pix_q + PIX_W'(1);
                buf_d       = '0;
            end else begin
                buf_d[shamt +: INPUT_DATA_WIDTH] = pixel_data;
                slot_d = slot_q + SLOT_W'(1);
                pix_d  = pix_q + PIX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            pix_q   <= '0;
            buf_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            pix_q   <= pix_d;
            buf_q   <= buf_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign data_out_valid = valid_q;
    assign data_out_data  = beat_q.data;
    assign data_out_keep  = beat_q.keep;
    assign data_out_last  = beat_q.last;
    assign image_done     = done_q;

endmodule
